// File: rtl/param_fifo.sv
// Single-clock synchronous FIFO with configurable width, depth and flag thresholds.
// It supports a registered read (FWFT=0) and a first-word-fall-through read (FWFT=1).
module param_fifo #(
    parameter int DW        = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0,
    localparam int CW       = $clog2(DEPTH + 1),
    localparam int PW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign full         = (count == COUNT_MAX);
    assign empty        = (count == '0);
    assign almost_full  = (32'(count) >= AFULL_TH);
    assign almost_empty = (32'(count) <= AEMPTY_TH);

    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            overflow  <= push & full;
            // A pop on an empty FIFO is not an error when a push lands in the same cycle.
            underflow <= pop & empty & ~push;
        end
    end

    // NOTE: the storage array has no reset so it maps onto block RAM; only the
    // pointers and count need a known state to make the contents meaningful.
    always_ff @(posedge clk) begin
        if (wr_en && !rst && !clr) begin
            mem[wr_ptr] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = empty ? '0 : mem[rd_ptr];
        end else begin : g_std
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_out <= '0;
                end else if (rd_en && !clr) begin
                    data_out <= mem[rd_ptr];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_param_fifo.sv
// Randomised and directed bench for param_fifo: instance 0 uses the defaults (registered read),
// instance 1 is DEPTH=5 first-word-fall-through; both are scored against a queue model.
module tb_param_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] push_s = '0;
    logic [1:0] pop_s  = '0;
    logic [1:0] clr_s  = '0;
    logic [1:0] rst_s  = '0;
    logic [7:0] din [2];

    wire  [7:0] dout [2];
    wire  [1:0] full_o, empty_o, af_o, ae_o, ovf_o, unf_o;
    wire  [4:0] cnt0;
    wire  [2:0] cnt1;

    param_fifo u_std (
        .clk(clk), .rst(rst_s[0]), .clr(clr_s[0]), .push(push_s[0]), .pop(pop_s[0]),
        .data_in(din[0]), .data_out(dout[0]), .full(full_o[0]), .empty(empty_o[0]),
        .almost_full(af_o[0]), .almost_empty(ae_o[0]), .count(cnt0),
        .overflow(ovf_o[0]), .underflow(unf_o[0])
    );

    param_fifo #(.DEPTH(5), .FWFT(1)) u_fw (
        .clk(clk), .rst(rst_s[1]), .clr(clr_s[1]), .push(push_s[1]), .pop(pop_s[1]),
        .data_in(din[1]), .data_out(dout[1]), .full(full_o[1]), .empty(empty_o[1]),
        .almost_full(af_o[1]), .almost_empty(ae_o[1]), .count(cnt1),
        .overflow(ovf_o[1]), .underflow(unf_o[1])
    );

    // Reference model configuration, one entry per instance.
    int dep   [2] = '{16, 5};
    int af_th [2] = '{14, 3};
    int ae_th [2] = '{2, 2};
    bit fwft  [2] = '{1'b0, 1'b1};

    logic [7:0] mq    [2][$];
    logic [7:0] exp_q [2][$];
    logic [7:0] last_out [2];
    bit         exp_ovf  [2];
    bit         exp_unf  [2];
    bit         armed    [2];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int inst, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s[%0d] t=%0t actual=%0h required=%0h", name, inst, $time, act, req);
        end
    endtask

    // Model: sample the same inputs the DUTs see at each rising edge.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int sz;
            sz = mq[i].size();
            if (rst_s[i]) begin
                mq[i].delete();
                exp_q[i].delete();
                exp_q[i].push_back(8'h00);
                exp_ovf[i] = 1'b0;
                exp_unf[i] = 1'b0;
                armed[i]   = 1'b1;
            end else if (clr_s[i]) begin
                mq[i].delete();
                exp_ovf[i] = 1'b0;
                exp_unf[i] = 1'b0;
            end else begin
                exp_ovf[i] = push_s[i] && (sz == dep[i]);
                exp_unf[i] = pop_s[i] && (sz == 0) && !push_s[i];
                if (pop_s[i] && sz > 0) begin
                    logic [7:0] head;
                    head = mq[i].pop_front();
                    if (!fwft[i]) exp_q[i].push_back(head);
                end
                if (push_s[i] && sz < dep[i]) mq[i].push_back(din[i]);
            end
        end
    end

    // Monitor: compare DUT outputs against the model mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (armed[i]) begin
                int c;
                logic [63:0] dut_cnt;
                c       = mq[i].size();
                dut_cnt = (i == 0) ? 64'(cnt0) : 64'(cnt1);
                check("count", i, dut_cnt, 64'(c));
                check("full", i, full_o[i], c == dep[i]);
                check("empty", i, empty_o[i], c == 0);
                check("almost_full", i, af_o[i], c >= af_th[i]);
                check("almost_empty", i, ae_o[i], c <= ae_th[i]);
                check("overflow", i, ovf_o[i], exp_ovf[i]);
                check("underflow", i, unf_o[i], exp_unf[i]);
                if (fwft[i]) begin
                    check("data_out", i, dout[i], (c > 0) ? mq[i][0] : 8'h00);
                end else begin
                    if (exp_q[i].size() > 0) last_out[i] = exp_q[i].pop_front();
                    check("data_out", i, dout[i], last_out[i]);
                end
            end
        end
    end

    task automatic set_in(input int i, input bit ps, input bit pp, input bit cl,
                          input bit rs, input logic [7:0] d);
        push_s[i] = ps;
        pop_s[i]  = pp;
        clr_s[i]  = cl;
        rst_s[i]  = rs;
        din[i]    = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One directed cycle on instance i with the other instance idle.
    task automatic op(input int i, input bit ps, input bit pp, input bit cl, input bit rs,
                      input logic [7:0] d);
        set_in(0, 0, 0, 0, 0, 8'h00);
        set_in(1, 0, 0, 0, 0, 8'h00);
        set_in(i, ps, pp, cl, rs, d);
        tick();
        set_in(i, 0, 0, 0, 0, 8'h00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_in(0, 0, 0, 0, 1, 8'h00);
        set_in(1, 0, 0, 0, 1, 8'h00);
        tick();
        tick();
        set_in(0, 0, 0, 0, 0, 8'h00);
        set_in(1, 0, 0, 0, 0, 8'h00);
        tick();

        // Registered-read instance: fill, drain, then error and edge cases.
        for (int k = 1; k <= 16; k++) op(0, 1, 0, 0, 0, 8'(k));
        for (int k = 0; k < 16; k++) op(0, 0, 1, 0, 0, 8'h00);
        op(0, 0, 0, 0, 0, 8'h00);
        for (int k = 0; k < 16; k++) op(0, 1, 0, 0, 0, 8'(8'h80 + k));
        op(0, 1, 0, 0, 0, 8'hAA);
        op(0, 0, 0, 0, 0, 8'h00);
        op(0, 1, 1, 0, 0, 8'hBB);
        for (int k = 0; k < 16; k++) op(0, 0, 1, 0, 0, 8'h00);
        op(0, 1, 1, 0, 0, 8'h5A);
        op(0, 0, 1, 0, 0, 8'h00);
        op(0, 0, 1, 0, 0, 8'h00);
        for (int k = 0; k < 7; k++) op(0, 1, 0, 0, 0, 8'(8'h30 + k));
        op(0, 1, 0, 1, 0, 8'hC1);
        op(0, 0, 1, 0, 0, 8'h00);
        for (int k = 0; k < 7; k++) op(0, 1, 0, 0, 0, 8'(8'h40 + k));
        op(0, 1, 1, 0, 1, 8'hC2);
        op(0, 1, 0, 0, 0, 8'h77);
        op(0, 0, 1, 0, 0, 8'h00);
        op(0, 0, 0, 0, 0, 8'h00);

        // Fall-through instance: two full passes to exercise pointer wrap at DEPTH=5.
        for (int pass = 0; pass < 2; pass++) begin
            op(1, 1, 0, 0, 0, 8'h11);
            op(1, 0, 0, 0, 0, 8'h00);
            for (int k = 2; k <= 5; k++) op(1, 1, 0, 0, 0, 8'(8'h11 * k));
            op(1, 1, 0, 0, 0, 8'hEE);
            for (int k = 0; k < 6; k++) op(1, 0, 1, 0, 0, 8'h00);
        end
        for (int k = 0; k < 3; k++) op(1, 1, 0, 0, 0, 8'(8'h60 + k));
        op(1, 1, 1, 1, 0, 8'hC3);
        op(1, 1, 1, 0, 0, 8'h99);
        op(1, 0, 1, 0, 0, 8'h00);

        // Random traffic on both instances at once.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 2; i++) begin
                set_in(i, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                       $urandom_range(0, 99) < 2, $urandom_range(0, 199) < 1,
                       8'($urandom_range(0, 255)));
            end
            tick();
        end
        set_in(0, 0, 0, 0, 0, 8'h00);
        set_in(1, 0, 0, 0, 0, 8'h00);
        tick();
        tick();

        check("scoreboard_drained", 0, 64'(exp_q[0].size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
